// File: rtl/rename_maptable_ckpt_pkg.sv
// Shared types and sizing for the rename map table and its checkpoint ring.
package rename_maptable_ckpt_pkg;
    localparam int DP_NUM        = 3;
    localparam int MT_ENTRY      = 32;
    localparam int PRF_NUM       = 64;
    localparam int CDB_NUM       = 2;
    localparam int TAG_IDX_WIDTH = 6;
    localparam int CKPT_NUM      = 4;
    localparam int AREG_W        = $clog2(MT_ENTRY);
    localparam int CKPT_IDX_W    = $clog2(CKPT_NUM);

    typedef logic [TAG_IDX_WIDTH-1:0] tag_t;
    typedef logic [AREG_W-1:0]        areg_t;

    typedef struct packed {
        logic valid;
        tag_t tag;
    } cdb_t;

    typedef struct packed {
        logic  read_en;
        areg_t rs1;
        areg_t rs2;
        logic  wr_en;
        areg_t rd;
        tag_t  tag;
    } dp_mt_t;

    typedef struct packed {
        tag_t tag;
    } amt_entry_t;

    typedef struct packed {
        tag_t tag1;
        logic tag1_ready;
        tag_t tag2;
        logic tag2_ready;
        tag_t tag_old;
    } mt_dp_t;

    typedef tag_t [MT_ENTRY-1:0] mt_ckpt_t;
endpackage

// File: rtl/rename_maptable_ckpt_mt_ckpt_ring.sv
// Checkpoint ring: full-map snapshots with head/tail pointers carrying an extra
// wrap bit so full and empty are distinguishable.
module mt_ckpt_ring
    import rename_maptable_ckpt_pkg::*;
#(
    parameter int C_CKPT_NUM = CKPT_NUM,
    localparam int IDX_W     = $clog2(C_CKPT_NUM),
    localparam int PTR_W     = IDX_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             alloc_i,
    input  mt_ckpt_t         alloc_map_i,
    input  logic             free_i,
    input  logic             recover_i,
    input  logic [IDX_W-1:0] recover_id_i,
    output logic [IDX_W-1:0] alloc_id_o,
    output logic             full_o,
    output mt_ckpt_t         recover_map_o
);
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [IDX_W-1:0] offset;
    logic             empty;
    logic             do_alloc;
    logic             do_free;
    mt_ckpt_t         ckpt [C_CKPT_NUM];

    assign full_o        = (tail - head) == PTR_W'(C_CKPT_NUM);
    assign empty         = head == tail;
    assign alloc_id_o    = tail[IDX_W-1:0];
    assign recover_map_o = ckpt[recover_id_i];
    assign do_alloc      = alloc_i & ~full_o & ~recover_i & ~flush_i;
    assign do_free       = free_i & ~empty & ~flush_i;
    // Distance of the restored checkpoint from the oldest live one.
    assign offset        = recover_id_i - head[IDX_W-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head <= '0;
            tail <= '0;
        end else if (flush_i) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (do_free)
                head <= head + PTR_W'(1);
            if (recover_i)
                tail <= head + {1'b0, offset} + PTR_W'(1);
            else if (do_alloc)
                tail <= tail + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_alloc)
            ckpt[tail[IDX_W-1:0]] <= alloc_map_i;
    end

    a_free_nonempty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(free_i && !flush_i && empty));
    a_recover_not_head: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(recover_i && free_i && !flush_i && recover_id_i == head[IDX_W-1:0]));
endmodule

// File: rtl/rename_maptable_ckpt.sv
// Rename map table: combinational source/old-tag lookup with intra-group
// forwarding and CDB bypass, plus single-cycle branch checkpoint restore.
module rename_maptable_ckpt
    import rename_maptable_ckpt_pkg::*;
#(
    parameter int C_DP_NUM   = DP_NUM,
    parameter int C_CDB_NUM  = CDB_NUM,
    parameter int C_CKPT_NUM = CKPT_NUM,
    localparam int IDX_W     = $clog2(C_CKPT_NUM)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rollback_i,
    input  cdb_t             cdb_i [C_CDB_NUM],
    input  dp_mt_t           dp_mt_i [C_DP_NUM],
    input  amt_entry_t       amt_i [MT_ENTRY],
    output mt_dp_t           mt_dp_o [C_DP_NUM],
    input  logic [C_DP_NUM-1:0] ckpt_req_i,
    output logic [IDX_W-1:0] ckpt_id_o,
    output logic             ckpt_full_o,
    input  logic             br_free_i,
    input  logic             br_recover_i,
    input  logic [IDX_W-1:0] br_recover_id_i
);
    mt_ckpt_t               map;
    logic [PRF_NUM-1:0]     ready_vec;
    logic [PRF_NUM-1:0]     ready_next;
    mt_ckpt_t               map_stage [C_DP_NUM];
    mt_ckpt_t               ckpt_map;
    mt_ckpt_t               recover_map;
    logic                   recover;
    logic [TAG_IDX_WIDTH:0] src1 [C_DP_NUM];
    logic [TAG_IDX_WIDTH:0] src2 [C_DP_NUM];
    logic [TAG_IDX_WIDTH:0] old  [C_DP_NUM];

    // Returns {forwarded, tag}: youngest older slot renaming r, else the map.
    function automatic logic [TAG_IDX_WIDTH:0] resolve(input areg_t r, input int slot);
        logic [TAG_IDX_WIDTH:0] res;
        res = {1'b0, map[r]};
        for (int j = 0; j < C_DP_NUM; j++)
            if (j < slot && dp_mt_i[j].wr_en && dp_mt_i[j].rd != '0 && dp_mt_i[j].rd == r)
                res = {1'b1, dp_mt_i[j].tag};
        return res;
    endfunction

    function automatic logic tag_ready(input tag_t t);
        logic rdy;
        rdy = ready_vec[t];
        for (int c = 0; c < C_CDB_NUM; c++)
            if (cdb_i[c].valid && cdb_i[c].tag == t)
                rdy = 1'b1;
        return rdy;
    endfunction

    always_comb begin
        for (int i = 0; i < C_DP_NUM; i++) begin
            src1[i] = resolve(dp_mt_i[i].rs1, i);
            src2[i] = resolve(dp_mt_i[i].rs2, i);
            old[i]  = resolve(dp_mt_i[i].rd, i);
            mt_dp_o[i] = '0;
            mt_dp_o[i].tag_old = old[i][TAG_IDX_WIDTH-1:0];
            if (dp_mt_i[i].read_en) begin
                mt_dp_o[i].tag1       = src1[i][TAG_IDX_WIDTH-1:0];
                mt_dp_o[i].tag1_ready = ~src1[i][TAG_IDX_WIDTH] & tag_ready(src1[i][TAG_IDX_WIDTH-1:0]);
                mt_dp_o[i].tag2       = src2[i][TAG_IDX_WIDTH-1:0];
                mt_dp_o[i].tag2_ready = ~src2[i][TAG_IDX_WIDTH] & tag_ready(src2[i][TAG_IDX_WIDTH-1:0]);
            end
        end
    end

    // map_stage[i] is the map after renames of slots 0..i.
    always_comb begin
        mt_ckpt_t m;
        m = map;
        for (int i = 0; i < C_DP_NUM; i++) begin
            if (dp_mt_i[i].wr_en && dp_mt_i[i].rd != '0)
                m[dp_mt_i[i].rd] = dp_mt_i[i].tag;
            map_stage[i] = m;
        end
        ckpt_map = map;
        for (int k = 0; k < C_DP_NUM; k++)
            if (ckpt_req_i[k])
                ckpt_map = map_stage[k];
    end

    always_comb begin
        ready_next = ready_vec;
        for (int c = 0; c < C_CDB_NUM; c++)
            if (cdb_i[c].valid)
                ready_next[cdb_i[c].tag] = 1'b1;
        if (!recover)
            for (int i = 0; i < C_DP_NUM; i++)
                if (dp_mt_i[i].wr_en && dp_mt_i[i].rd != '0)
                    ready_next[dp_mt_i[i].tag] = 1'b0;
    end

    assign recover = br_recover_i & ~rollback_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < MT_ENTRY; r++)
                map[r] <= tag_t'(r);
            ready_vec <= '1;
        end else if (rollback_i) begin
            for (int r = 0; r < MT_ENTRY; r++)
                map[r] <= amt_i[r].tag;
            ready_vec <= '1;
        end else begin
            map       <= recover ? recover_map : map_stage[C_DP_NUM-1];
            ready_vec <= ready_next;
        end
    end

    mt_ckpt_ring #(.C_CKPT_NUM(C_CKPT_NUM)) u_ring (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (rollback_i),
        .alloc_i       (|ckpt_req_i),
        .alloc_map_i   (ckpt_map),
        .free_i        (br_free_i),
        .recover_i     (recover),
        .recover_id_i  (br_recover_id_i),
        .alloc_id_o    (ckpt_id_o),
        .full_o        (ckpt_full_o),
        .recover_map_o (recover_map)
    );

    a_req_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(ckpt_req_i));
    a_req_not_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(|ckpt_req_i && ckpt_full_o && !recover && !rollback_i));
endmodule

// File: tb/tb_rename_maptable_ckpt.sv
// Bench for rename_maptable_ckpt: directed scenarios with literal expectations
// followed by random traffic compared every cycle against a behavioural model.
module tb_rename_maptable_ckpt;
    import rename_maptable_ckpt_pkg::*;

    logic                  clk_i = 1'b0;
    logic                  rst_ni = 1'b0;
    logic                  rollback_i;
    cdb_t                  cdb_i [CDB_NUM];
    dp_mt_t                dp_mt_i [DP_NUM];
    amt_entry_t            amt_i [MT_ENTRY];
    mt_dp_t                mt_dp_o [DP_NUM];
    logic [DP_NUM-1:0]     ckpt_req_i;
    logic [CKPT_IDX_W-1:0] ckpt_id_o;
    logic                  ckpt_full_o;
    logic                  br_free_i;
    logic                  br_recover_i;
    logic [CKPT_IDX_W-1:0] br_recover_id_i;

    always #5 clk_i = ~clk_i;

    rename_maptable_ckpt dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .rollback_i(rollback_i), .cdb_i(cdb_i),
        .dp_mt_i(dp_mt_i), .amt_i(amt_i), .mt_dp_o(mt_dp_o), .ckpt_req_i(ckpt_req_i),
        .ckpt_id_o(ckpt_id_o), .ckpt_full_o(ckpt_full_o), .br_free_i(br_free_i),
        .br_recover_i(br_recover_i), .br_recover_id_i(br_recover_id_i)
    );

    int errors = 0;
    int checks = 0;

    // Model: architectural map, ready bits, and a list of live snapshots
    // starting at m_head with m_count entries.
    int unsigned m_map [MT_ENTRY];
    bit          m_ready [PRF_NUM];
    int unsigned m_ck [CKPT_NUM][MT_ENTRY];
    int          m_head;
    int          m_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < MT_ENTRY; r++) m_map[r] = r;
        for (int t = 0; t < PRF_NUM; t++) m_ready[t] = 1'b1;
        m_head = 0;
        m_count = 0;
    endtask

    task automatic clear_inputs();
        rollback_i = 1'b0;
        ckpt_req_i = '0;
        br_free_i = 1'b0;
        br_recover_i = 1'b0;
        br_recover_id_i = '0;
        for (int c = 0; c < CDB_NUM; c++) cdb_i[c] = '0;
        for (int i = 0; i < DP_NUM; i++) dp_mt_i[i] = '0;
        for (int r = 0; r < MT_ENTRY; r++) amt_i[r].tag = tag_t'(r);
    endtask

    function automatic bit renames(input int j);
        return dp_mt_i[j].wr_en && dp_mt_i[j].rd != 0;
    endfunction

    task automatic exp_lookup(input int slot, input int unsigned r,
                              output int unsigned tag, output int unsigned rdy);
        bit found = 0;
        tag = m_map[r];
        rdy = m_ready[tag];
        for (int c = 0; c < CDB_NUM; c++)
            if (cdb_i[c].valid && cdb_i[c].tag == tag) rdy = 1;
        for (int j = slot - 1; j >= 0; j--)
            if (!found && renames(j) && dp_mt_i[j].rd == r) begin
                found = 1;
                tag = dp_mt_i[j].tag;
                rdy = 0;
            end
    endtask

    task automatic compare_model();
        int unsigned t, r;
        for (int i = 0; i < DP_NUM; i++) begin
            exp_lookup(i, dp_mt_i[i].rs1, t, r);
            if (!dp_mt_i[i].read_en) begin t = 0; r = 0; end
            chk($sformatf("slot%0d tag1", i), 32'(mt_dp_o[i].tag1), t);
            chk($sformatf("slot%0d tag1_ready", i), 32'(mt_dp_o[i].tag1_ready), r);
            exp_lookup(i, dp_mt_i[i].rs2, t, r);
            if (!dp_mt_i[i].read_en) begin t = 0; r = 0; end
            chk($sformatf("slot%0d tag2", i), 32'(mt_dp_o[i].tag2), t);
            chk($sformatf("slot%0d tag2_ready", i), 32'(mt_dp_o[i].tag2_ready), r);
            exp_lookup(i, dp_mt_i[i].rd, t, r);
            chk($sformatf("slot%0d tag_old", i), 32'(mt_dp_o[i].tag_old), t);
        end
        chk("ckpt_id", 32'(ckpt_id_o), (m_head + m_count) % CKPT_NUM);
        chk("ckpt_full", 32'(ckpt_full_o), 32'(m_count == CKPT_NUM));
    endtask

    task automatic model_update();
        bit nready [PRF_NUM];
        int unsigned tmp [MT_ENTRY];
        int id;
        bit alloc = 0;
        if (rollback_i) begin
            for (int r = 0; r < MT_ENTRY; r++) m_map[r] = amt_i[r].tag;
            for (int t = 0; t < PRF_NUM; t++) m_ready[t] = 1'b1;
            m_head = 0;
            m_count = 0;
            return;
        end
        nready = m_ready;
        for (int c = 0; c < CDB_NUM; c++)
            if (cdb_i[c].valid) nready[cdb_i[c].tag] = 1'b1;
        if (br_recover_i) begin
            id = br_recover_id_i;
            m_map = m_ck[id];
            m_count = ((id - m_head + CKPT_NUM) % CKPT_NUM) + 1;
            if (br_free_i) begin
                m_head = (m_head + 1) % CKPT_NUM;
                m_count--;
            end
        end else begin
            tmp = m_map;
            for (int i = 0; i < DP_NUM; i++) begin
                if (renames(i)) begin
                    tmp[dp_mt_i[i].rd] = dp_mt_i[i].tag;
                    nready[dp_mt_i[i].tag] = 1'b0;
                end
                if (ckpt_req_i[i] && m_count < CKPT_NUM) begin
                    m_ck[(m_head + m_count) % CKPT_NUM] = tmp;
                    alloc = 1;
                end
            end
            m_map = tmp;
            if (alloc) m_count++;
            if (br_free_i && m_count > 0) begin
                m_head = (m_head + 1) % CKPT_NUM;
                m_count--;
            end
        end
        m_ready = nready;
    endtask

    // Called #1 after inputs were driven at a negedge; ends at the next negedge.
    task automatic cyc();
        compare_model();
        model_update();
        @(negedge clk_i);
    endtask

    task automatic rand_inputs();
        clear_inputs();
        for (int i = 0; i < DP_NUM; i++) begin
            dp_mt_i[i].read_en = 1'($urandom_range(0, 1));
            dp_mt_i[i].rs1 = areg_t'($urandom_range(0, 7));
            dp_mt_i[i].rs2 = areg_t'($urandom_range(0, MT_ENTRY - 1));
            dp_mt_i[i].wr_en = 1'($urandom_range(0, 1));
            dp_mt_i[i].rd = areg_t'($urandom_range(0, 7));
            dp_mt_i[i].tag = tag_t'($urandom_range(1, PRF_NUM - 1));
        end
        for (int c = 0; c < CDB_NUM; c++) begin
            cdb_i[c].valid = 1'($urandom_range(0, 1));
            cdb_i[c].tag = tag_t'($urandom_range(0, PRF_NUM - 1));
            for (int i = 0; i < DP_NUM; i++)
                if (renames(i) && dp_mt_i[i].tag == cdb_i[c].tag) cdb_i[c].valid = 1'b0;
        end
        if (m_count < CKPT_NUM && $urandom_range(0, 2) == 0)
            ckpt_req_i[$urandom_range(0, DP_NUM - 1)] = 1'b1;
        if (m_count > 0 && $urandom_range(0, 3) == 0) br_free_i = 1'b1;
        if (m_count > 0 && $urandom_range(0, 11) == 0) begin
            br_recover_i = 1'b1;
            br_recover_id_i = CKPT_IDX_W'((m_head + $urandom_range(0, m_count - 1)) % CKPT_NUM);
            if (br_recover_id_i == m_head) br_free_i = 1'b0;
        end
        if ($urandom_range(0, 63) == 0) begin
            rollback_i = 1'b1;
            for (int r = 0; r < MT_ENTRY; r++) amt_i[r].tag = tag_t'($urandom_range(0, PRF_NUM - 1));
        end
    endtask

    initial begin
        clear_inputs();
        model_reset();
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Reset map lookup
        dp_mt_i[0].read_en = 1'b1; dp_mt_i[0].rs1 = 5; dp_mt_i[0].rs2 = 7;
        #1;
        chk("rst tag1", 32'(mt_dp_o[0].tag1), 5);
        chk("rst tag2", 32'(mt_dp_o[0].tag2), 7);
        chk("rst ready1", 32'(mt_dp_o[0].tag1_ready), 1);
        chk("rst ready2", 32'(mt_dp_o[0].tag2_ready), 1);
        chk("rst full", 32'(ckpt_full_o), 0);
        chk("rst id", 32'(ckpt_id_o), 0);
        cyc();

        // Intra-group forwarding
        clear_inputs();
        dp_mt_i[0].wr_en = 1'b1; dp_mt_i[0].rd = 3; dp_mt_i[0].tag = 40;
        dp_mt_i[1].wr_en = 1'b1; dp_mt_i[1].rd = 3; dp_mt_i[1].tag = 41;
        dp_mt_i[2].read_en = 1'b1; dp_mt_i[2].rs1 = 3;
        #1;
        chk("fwd slot2 tag1", 32'(mt_dp_o[2].tag1), 41);
        chk("fwd slot2 ready", 32'(mt_dp_o[2].tag1_ready), 0);
        chk("fwd slot1 tag_old", 32'(mt_dp_o[1].tag_old), 40);
        chk("fwd slot0 tag_old", 32'(mt_dp_o[0].tag_old), 3);
        cyc();
        clear_inputs();
        dp_mt_i[0].read_en = 1'b1; dp_mt_i[0].rs1 = 3;
        #1;
        chk("map3 after rename", 32'(mt_dp_o[0].tag1), 41);
        cyc();

        // CDB bypass then ready_vec update
        clear_inputs();
        dp_mt_i[0].wr_en = 1'b1; dp_mt_i[0].rd = 4; dp_mt_i[0].tag = 42;
        #1; cyc();
        clear_inputs();
        cdb_i[0].valid = 1'b1; cdb_i[0].tag = 42;
        dp_mt_i[0].read_en = 1'b1; dp_mt_i[0].rs1 = 4;
        #1;
        chk("cdb bypass tag", 32'(mt_dp_o[0].tag1), 42);
        chk("cdb bypass ready", 32'(mt_dp_o[0].tag1_ready), 1);
        cyc();
        clear_inputs();
        dp_mt_i[0].read_en = 1'b1; dp_mt_i[0].rs1 = 4;
        #1;
        chk("ready_vec set", 32'(mt_dp_o[0].tag1_ready), 1);
        cyc();

        // Checkpoint mid-group, then recover to it
        clear_inputs();
        dp_mt_i[1].wr_en = 1'b1; dp_mt_i[1].rd = 6; dp_mt_i[1].tag = 44;
        dp_mt_i[2].wr_en = 1'b1; dp_mt_i[2].rd = 6; dp_mt_i[2].tag = 45;
        ckpt_req_i = 3'b010;
        #1;
        chk("ckpt alloc id", 32'(ckpt_id_o), 0);
        cyc();
        clear_inputs();
        dp_mt_i[0].read_en = 1'b1; dp_mt_i[0].rs1 = 6;
        #1;
        chk("map6 pre-recover", 32'(mt_dp_o[0].tag1), 45);
        chk("id after alloc", 32'(ckpt_id_o), 1);
        cyc();
        clear_inputs();
        br_recover_i = 1'b1; br_recover_id_i = 0;
        #1; cyc();
        clear_inputs();
        dp_mt_i[0].read_en = 1'b1; dp_mt_i[0].rs1 = 6;
        #1;
        chk("map6 recovered", 32'(mt_dp_o[0].tag1), 44);
        chk("tail after recover", 32'(ckpt_id_o), 1);
        cyc();

        // Fill, free, wrap
        for (int n = 1; n <= 3; n++) begin
            clear_inputs();
            ckpt_req_i = 3'b001;
            #1;
            chk("fill id", 32'(ckpt_id_o), n);
            cyc();
        end
        clear_inputs();
        #1;
        chk("full set", 32'(ckpt_full_o), 1);
        br_free_i = 1'b1;
        cyc();
        clear_inputs();
        ckpt_req_i = 3'b100;
        #1;
        chk("full clear", 32'(ckpt_full_o), 0);
        chk("wrap id", 32'(ckpt_id_o), 0);
        cyc();

        // Rollback overrides a simultaneous recover
        clear_inputs();
        rollback_i = 1'b1; br_recover_i = 1'b1; br_recover_id_i = 2;
        for (int r = 0; r < MT_ENTRY; r++) amt_i[r].tag = tag_t'(r + 32);
        #1; cyc();
        for (int base = 0; base < MT_ENTRY; base += 2 * DP_NUM) begin
            clear_inputs();
            for (int i = 0; i < DP_NUM; i++) begin
                dp_mt_i[i].read_en = 1'b1;
                dp_mt_i[i].rs1 = areg_t'((base + 2 * i) % MT_ENTRY);
                dp_mt_i[i].rs2 = areg_t'((base + 2 * i + 1) % MT_ENTRY);
            end
            #1;
            for (int i = 0; i < DP_NUM; i++) begin
                chk("rollback tag1", 32'(mt_dp_o[i].tag1), ((base + 2 * i) % MT_ENTRY) + 32);
                chk("rollback ready1", 32'(mt_dp_o[i].tag1_ready), 1);
                chk("rollback tag2", 32'(mt_dp_o[i].tag2), ((base + 2 * i + 1) % MT_ENTRY) + 32);
            end
            chk("rollback full", 32'(ckpt_full_o), 0);
            chk("rollback id", 32'(ckpt_id_o), 0);
            cyc();
        end

        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            #1;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rename_maptable_ckpt.md
# rename_maptable_ckpt

Parametrised register map table for the rename/dispatch stage. Translates up to C_DP_NUM architectural sources and destinations per cycle into physical tags, with dependency forwarding across all dispatch slots and CDB wakeup bypass on every slot. Holds C_CKPT_NUM branch checkpoints so a mispredicted branch restores the map in one cycle without waiting for the AMT. Sits between the decoder/freelist and the dispatch logic (RS/ROB); the AMT supplies the committed map for a full flush.

## Interface
- C_DP_NUM, `DP_NUM: dispatch slots per cycle (1..4).
- C_MT_ENTRY, `MT_ENTRY: architectural registers (32).
- C_PRF_NUM, `PRF_NUM: physical registers (64).
- C_CDB_NUM, `CDB_NUM: CDB broadcast ports.
- C_TAG_IDX_WIDTH, `TAG_IDX_WIDTH: physical tag width, ≥ clog2(C_PRF_NUM).
- C_CKPT_NUM, 4: checkpoint slots (power of 2).
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  asynchronous, active-low reset.
- rollback_i  in  1  full flush; map reloads from amt_i.
- cdb_i  in  CDB[C_CDB_NUM]  completion broadcasts (valid, tag).
- dp_mt_i  in  DP_MT[C_DP_NUM]  per slot: read_en, rs1, rs2, wr_en, rd, tag (new tag from freelist).
- amt_i  in  AMT_ENTRY[C_MT_ENTRY]  committed map.
- mt_dp_o  out  MT_DP[C_DP_NUM]  per slot: tag1, tag1_ready, tag2, tag2_ready, tag_old.
- ckpt_req_i  in  C_DP_NUM  one-hot-or-zero; slot k holds a branch.
- ckpt_id_o  out  clog2(C_CKPT_NUM)  id allocated this cycle (valid with ckpt_req_i).
- ckpt_full_o  out  1  no free checkpoint; dispatch must not assert ckpt_req_i.
- br_free_i  in  1  oldest checkpoint released (branch committed correct).
- br_recover_i  in  1  mispredict recovery.
- br_recover_id_i  in  clog2(C_CKPT_NUM)  checkpoint to restore.

## Operation
- State: map[C_MT_ENTRY] of tags; ready_vec[C_PRF_NUM]; checkpoint ring ckpt[C_CKPT_NUM] of full maps; head, tail pointers (width clog2+1 for full/empty).
- Reset (rst_ni=0, async): map[r]=r; ready_vec all 1; head=tail=0. Outputs combinational, so mt_dp_o follows reset map; ckpt_full_o=0, ckpt_id_o=0.
- Source lookup, slot i, source s (combinational): if read_en=0 -> tag=0, ready=0. Else if any slot j<i has wr_en, rd≠0 and rd==rs -> tag = dp_mt_i[j].tag of the highest such j, ready=0. Else tag=map[rs], ready = ready_vec[tag] OR any cdb_i valid with matching tag.
- tag_old, slot i (combinational, same cycle): same forwarding rule on rd (highest j<i writing rd), else map[rd].
- rd==0: wr_en ignored (never renamed); tag_old=map[0].
- Update on clock, no flush/recover: for each slot with wr_en and rd≠0, map[rd] <= tag in slot order (highest slot wins); ready_vec[tag] <= 0. CDB valid tags set ready_vec <= 1; a set and a clear of the same tag in one cycle cannot occur legally; clear wins.
- Checkpoint: with ckpt_req_i[k], ckpt[tail] <= map including renames of slots 0..k only (excludes slots >k); ckpt_id_o=tail[low bits]; tail++. Request while full is ignored (asserted illegal).
- br_free_i: head++ (free while empty asserted illegal).
- br_recover_i: map <= ckpt[id]; tail <= id+1 (younger checkpoints discarded); ready_vec untouched except CDB sets. Same-cycle dispatch writes and ckpt_req_i ignored. Same-cycle br_free_i legal and applied unless id == head (asserted illegal).
- rollback_i: map <= amt_i tags; ready_vec all 1; head=tail=0; dispatch, checkpoint, free, recover ignored.
- Priority: reset > rollback_i > br_recover_i > dispatch/checkpoint; CDB ready-set applies in every non-reset case except rollback.

## Timing
- Lookup and tag_old: zero latency, combinational from dp_mt_i/cdb_i/state.
- Rename, checkpoint, recover, rollback visible to lookups the next cycle.
- ckpt_full_o = (tail−head == C_CKPT_NUM), registered-state derived; pointer wrap by modular index with extra MSB.

## Structure
- Shared package: MT_CKPT (array of C_MT_ENTRY tags), add CKPT_NUM and PRF_NUM defines; DP_MT gains no fields, MT_DP unchanged.
- Sub-module mt_ckpt_ring: checkpoint storage, pointers, full/empty, allocate/free/truncate.

## Test plan
- Reset then slot0 read rs1=5, rs2=7 -> tag1=5, tag2=7, both ready=1.
- C_DP_NUM=3: slot0 rd=3 tag=40, slot1 rd=3 tag=41, slot2 rs1=3 -> slot2 tag1=41 ready=0; slot1 tag_old=40; next cycle map[3]=41.
- Rename rd=4->tag 42, then cycle with cdb tag 42 valid and lookup rs1=4 -> tag1=42 ready=1 same cycle; next cycle ready_vec[42]=1.
- Slot1 ckpt_req with slot2 rd=6 tag=45 (slot1 rd=6 tag=44) -> ckpt stores 44; later br_recover to that id -> map[6]=44, tail=id+1.
- Allocate 4 checkpoints -> ckpt_full_o=1; br_free_i -> 0; wrap-around allocation id=0 again.
- rollback_i with amt map[r]=r+32 -> all lookups return r+32 ready=1, ckpt_full_o=0, simultaneous br_recover_i ignored.
